// File: rtl/pb_event_arbiter.sv
// pb_event_arbiter
// Push-button front end. Every raw button is synchronized, then debounced
// against one shared sample tick. A debounced press sets a pending bit, and
// pending presses go out one at a time through a round-robin valid/ready port.
module pb_event_arbiter #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         pb_in,
    output logic [N_BTN-1:0]         pb_level,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    input  logic                     evt_ready,
    output logic                     evt_overrun
);

    // N_BTN is at least 2, so $clog2 is always at least 1.
    localparam int IDW = $clog2(N_BTN);
    localparam int TCW = $clog2(TICK_DIV);
    localparam int SCW = $clog2(STABLE_CNT);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [TCW-1:0]   tick_cnt;
    logic             tick;
    logic [SCW-1:0]   cnt     [N_BTN];
    logic [SCW-1:0]   cnt_nxt [N_BTN];
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] clr;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic             found;
    logic             out_free;
    logic             load;

    // Index reached by stepping 'step' positions past 'base', wrapping at N_BTN.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int step);
        int t;
        t = int'(base) + step;
        return IDW'(t % N_BTN);
    endfunction

    // Two-flop synchronizer on the raw asynchronous button pins.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pb_in;
            sync2 <= sync1;
        end
    end

    assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

    // Shared sample-tick divider, wraps after TICK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Per-button debounce next state; a level flip to 1 is a press (rise).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        level_nxt = pb_level;
        rise      = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_nxt[i] = cnt[i];
            if (tick) begin
                if (sync2[i] == pb_level[i]) begin
                    cnt_nxt[i] = '0;
                end else if (int'(cnt[i]) + 1 == STABLE_CNT) begin
                    level_nxt[i] = sync2[i];
                    cnt_nxt[i]   = '0;
                    rise[i]      = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels and their stable-sample counters.
    always_ff @(posedge clk) begin
        // NOTE: the counter array is small control state, so it is reset like any register.
        if (rst) begin
            pb_level <= '0;
            cnt      <= '{default: '0};
        end else begin
            pb_level <= level_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // Round-robin search for the first pending button after last_grant.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!found && pending[rr_idx(last_grant, k)]) begin
                found  = 1'b1;
                winner = rr_idx(last_grant, k);
            end
        end
    end

    assign out_free = !evt_valid || evt_ready;
    assign load     = out_free && (|pending);

    // One-hot clear of the button being loaded into the output register.
    always_comb begin
        clr = '0;
        if (load) begin
            clr[winner] = 1'b1;
        end
    end

    // Pending presses; a new press wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            evt_overrun <= 1'b0;
        end else begin
            pending     <= (pending & ~clr) | rise;
            evt_overrun <= |(rise & pending & ~clr);
        end
    end

    // Output register: refill when free, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            last_grant <= IDW'(N_BTN - 1);
        end else if (out_free) begin
            evt_valid <= load;
            if (load) begin
                evt_id     <= winner;
                last_grant <= winner;
            end
        end
    end

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Self-checking bench for pb_event_arbiter (N_BTN=4, TICK_DIV=4, STABLE_CNT=3).
// A behavioural model predicts the outputs every cycle; directed scenarios add
// hand-derived expectations on event order, counts and reset behaviour.
module tb_pb_event_arbiter;

    localparam int N_BTN      = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pb_in;
    logic [3:0] pb_level;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic       evt_overrun;

    pb_event_arbiter #(
        .N_BTN     (N_BTN),
        .TICK_DIV  (TICK_DIV),
        .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pb_in      (pb_in),
        .pb_level   (pb_level),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       started = 1'b0;
    bit [3:0] m_s1, m_s2;
    int       m_div;
    int       m_run [4];
    bit [3:0] m_level;
    bit [3:0] m_pend;
    int       m_last;
    bit       m_valid;
    int       m_id;
    bit       m_ovr;

    task automatic model_step();
        bit       tick;
        bit [3:0] rise;
        bit [3:0] clr;
        bit       done;
        int       idx;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_div = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_level = '0; m_pend = '0; m_last = N_BTN - 1;
            m_valid = 1'b0; m_id = 0; m_ovr = 1'b0;
            started = 1'b1;
            return;
        end
        if (!started) return;
        tick  = (m_div == TICK_DIV - 1);
        m_div = (m_div + 1) % TICK_DIV;
        rise  = '0;
        for (int i = 0; i < 4; i++) begin
            if (tick) begin
                if (m_s2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STABLE_CNT) begin
                        m_level[i] = m_s2[i];
                        m_run[i]   = 0;
                        rise[i]    = m_level[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = pb_in;
        clr  = '0;
        if (!m_valid || evt_ready) begin
            if (m_pend != 0) begin
                done = 1'b0;
                for (int k = 1; k <= N_BTN; k++) begin
                    idx = (m_last + k) % N_BTN;
                    if (!done && m_pend[idx]) begin
                        done    = 1'b1;
                        m_id    = idx;
                        m_last  = idx;
                        clr[idx] = 1'b1;
                    end
                end
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_ovr  = |(rise & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | rise;
    endtask

    always @(posedge clk) model_step();

    // ---------------- compare and logging ----------------
    int       acc_q [$];
    int       n_ovr;
    int       n_vcyc;
    bit [3:0] lvl_seen;

    always @(negedge clk) begin
        if (started) begin
            check("pb_level", int'(pb_level), int'(m_level));
            check("evt_valid", int'(evt_valid), int'(m_valid));
            check("evt_id", int'(evt_id), m_id);
            check("evt_overrun", int'(evt_overrun), int'(m_ovr));
            if (evt_valid && evt_ready) acc_q.push_back(int'(evt_id));
            if (evt_overrun) n_ovr++;
            if (evt_valid) n_vcyc++;
            lvl_seen |= pb_level;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        n_ovr    = 0;
        n_vcyc   = 0;
        lvl_seen = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_valid(input int max_cyc, input string name);
        int n = 0;
        while (!evt_valid && n < max_cyc) begin
            cyc(1);
            n++;
        end
        check(name, int'(evt_valid), 1);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_level"}, int'(pb_level), 0);
        check({name, "_valid"}, int'(evt_valid), 0);
        check({name, "_id"}, int'(evt_id), 0);
        check({name, "_ovr"}, int'(evt_overrun), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        pb_in     = '0;
        evt_ready = 1'b0;
        cyc(1);
        rst = 1'b0;
        clear_logs();
        check_zero_outputs("reset_state");

        // Clean press on button 0 with the consumer always ready.
        begin
            int n = 0;
            evt_ready = 1'b1;
            pb_in     = 4'b0001;
            while (!pb_level[0] && n < 20) begin
                cyc(1);
                n++;
            end
            check("clean_level", int'(pb_level[0]), 1);
            check("clean_latency_ok", int'(n <= 14), 1);
            cyc(10);
            check("clean_events", acc_q.size(), 1);
            if (acc_q.size() == 1) check("clean_id", acc_q[0], 0);
            check("clean_valid_cycles", n_vcyc, 1);
            pb_in = '0;
            cyc(30);
            check("release_level", int'(pb_level[0]), 0);
            check("release_no_event", acc_q.size(), 1);
        end

        // Bounce on button 2: alternating sample every tick.
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pb_in[2] = ~pb_in[2];
            cyc(4);
        end
        pb_in = '0;
        cyc(20);
        check("bounce_level_seen", int'(lvl_seen[2]), 0);
        check("bounce_valid_cycles", n_vcyc, 0);
        check("bounce_overruns", n_ovr, 0);

        // Stall with three simultaneous presses, then drain in order.
        do_reset();
        evt_ready = 1'b0;
        pb_in     = 4'b1110;
        wait_valid(30, "stall_valid_timeout");
        check("stall_first_id", int'(evt_id), 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("stall_hold_id", int'(evt_id), 1);
            check("stall_hold_valid", int'(evt_valid), 1);
        end
        evt_ready = 1'b1;
        cyc(5);
        check("stall_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("stall_order0", acc_q[0], 1);
            check("stall_order1", acc_q[1], 2);
            check("stall_order2", acc_q[2], 3);
        end
        check("stall_drained", int'(evt_valid), 0);
        pb_in = '0;
        cyc(30);

        // Round robin: grant button 2 first, then 0 and 3 together -> 3, 0.
        do_reset();
        evt_ready = 1'b1;
        pb_in     = 4'b0100;
        cyc(20);
        pb_in = '0;
        cyc(20);
        check("rr_setup", acc_q.size(), 1);
        clear_logs();
        pb_in = 4'b1001;
        cyc(20);
        check("rr_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("rr_first", acc_q[0], 3);
            check("rr_second", acc_q[1], 0);
        end
        pb_in = '0;
        cyc(30);

        // Overrun: three presses of button 1 while the consumer stalls.
        do_reset();
        evt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pb_in = 4'b0010;
            cyc(20);
            pb_in = '0;
            cyc(20);
        end
        check("ovr_pulses", n_ovr, 1);
        check("ovr_valid", int'(evt_valid), 1);
        check("ovr_id", int'(evt_id), 1);
        evt_ready = 1'b1;
        cyc(10);
        check("ovr_transfers", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("ovr_t0", acc_q[0], 1);
            check("ovr_t1", acc_q[1], 1);
        end

        // Reset mid-flight with buttons released: nothing follows.
        do_reset();
        evt_ready = 1'b0;
        pb_in     = 4'b0011;
        wait_valid(30, "midrst_a_timeout");
        pb_in = '0;
        rst   = 1'b1;
        cyc(1);
        check_zero_outputs("midrst_a");
        rst       = 1'b0;
        evt_ready = 1'b1;
        clear_logs();
        cyc(40);
        check("midrst_a_events", acc_q.size(), 0);

        // Reset mid-flight with button 0 still held: one fresh press of 0.
        evt_ready = 1'b0;
        pb_in     = 4'b0011;
        wait_valid(30, "midrst_b_timeout");
        pb_in = 4'b0001;
        rst   = 1'b1;
        cyc(1);
        check_zero_outputs("midrst_b");
        rst       = 1'b0;
        evt_ready = 1'b1;
        clear_logs();
        cyc(40);
        check("midrst_b_events", acc_q.size(), 1);
        if (acc_q.size() == 1) check("midrst_b_id", acc_q[0], 0);
        pb_in = '0;
        cyc(30);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) pb_in[$urandom_range(0, 3)] ^= 1'b1;
            evt_ready = ($urandom_range(0, 99) < 50);
            rst       = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pb_event_arbiter.md
# pb_event_arbiter

Front-end controller for the push-button inputs. It shares one sample-tick generator across N_BTN raw buttons and debounces each button with a per-button stable-sample counter. Debounced press events are queued as one pending bit per button and handed to a single downstream consumer through a round-robin valid/ready port. It sits between the board pins and the control FSM, replacing per-button free-running debounce instances.

## Interface
- N_BTN, 4, number of buttons (2..16).
- TICK_DIV, 50000, clock cycles per debounce sample (1 ms at 50 MHz); ≥2.
- STABLE_CNT, 4, consecutive differing samples required to change a debounced level; ≥2.
- IDW (localparam), max(1, $clog2(N_BTN)), width of evt_id.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pb_in  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- pb_level  out  N_BTN  debounced levels.
- evt_valid  out  1  press event available.
- evt_id  out  IDW  index of the button whose press is presented.
- evt_ready  in  1  consumer accepts the event when evt_valid=1.
- evt_overrun  out  1  one-cycle pulse when a press is lost.

## Operation
- Synchronizer: each pb_in bit passes through 2 flops before any use.
- Tick: a counter counts 0..TICK_DIV-1 and wraps. Internal tick=1 for the single cycle in which counter==TICK_DIV-1.
- Debounce, per button i, evaluated only on tick cycles:
  - If sync[i]==pb_level[i], cnt[i]<=0.
  - Otherwise, if cnt[i]+1==STABLE_CNT, then pb_level[i]<=sync[i] and cnt[i]<=0. Else cnt[i]<=cnt[i]+1.
- Event creation: a 0→1 change of pb_level[i] sets pending[i]. A 1→0 change creates no event.
- Overrun: a rise on i while pending[i]=1 and i is not being loaded this cycle pulses evt_overrun for 1 cycle. pending[i] stays 1, so the extra press is lost.
- Output register load condition: load=(!evt_valid || evt_ready) && |pending.
  - On load, the winner is the first set pending bit searching last_grant+1, last_grant+2, … modulo N_BTN.
  - evt_id<=winner, evt_valid<=1, pending[winner] cleared, last_grant<=winner.
- If (!evt_valid || evt_ready) && pending==0, then evt_valid<=0.
- Stall: while evt_valid=1 and evt_ready=0, evt_id and evt_valid hold.
- Simultaneous set and clear of pending[i] in one cycle: set wins, so pending[i] stays 1 and no overrun is flagged.
- Back-to-back: with evt_ready held 1, one event is transferred per cycle.

## Timing
- Reset values, all applied the cycle after rst is sampled high:
  - sync flops, tick counter, cnt, pending, pb_level, evt_valid, evt_id and evt_overrun = 0.
  - last_grant = N_BTN-1, so button 0 has first priority.
- Reset mid-operation discards any presented or pending events.
- A button still held at reset release is re-detected as a new press after STABLE_CNT ticks.
- Press latency, from a stable pb_in edge:
  - 2 cycles for synchronization.
  - Then the STABLE_CNT-th subsequent tick updates pb_level and pending on the same edge.
  - evt_valid rises 1 cycle later when the output is free.
- Glitches shorter than STABLE_CNT consecutive samples never change pb_level.
- evt_overrun is registered and aligned with the pending update edge.

## Test plan
All scenarios use N_BTN=4, TICK_DIV=4, STABLE_CNT=3.
- Clean press: pb_in[0] 0→1 and held, evt_ready=1 -> pb_level[0]=1 after 2 sync cycles + 3 ticks (≤14 cycles). Exactly one evt_valid cycle with evt_id=0. No event on the later release.
- Bounce: pb_in[2] toggles every 4 cycles for 40 cycles, then 0 -> pb_level[2] stays 0, evt_valid never asserts, evt_overrun never asserts.
- Stall and order: buttons 1, 2 and 3 rise on the same tick; evt_ready=0 for 20 cycles, then 1 -> evt_id=1 held stable during the stall, then ids 2 and 3 on the next two cycles, then evt_valid=0.
- Round-robin: with last_grant=2 and pending={0,3} -> order 3 then 0.
- Overrun: evt_ready=0; press and release button 1 three times -> first press presented (evt_id=1), second press pending, third press gives a single 1-cycle evt_overrun. After evt_ready=1, exactly two events with id=1 are transferred.
- Reset mid-flight: rst for 1 cycle while evt_valid=1 and pending≠0 -> all outputs 0 the next cycle. With buttons released, no events follow. With button 0 held, one event with id=0 follows after the debounce latency.
